// File: rtl/nw_seq_loader.sv
// Needleman-Wunsch grid front-end: streams chars into s1/s2, sequences grid reset, returns score.
// One char per cycle when in_valid; result held on res_* until res_ready, no new chars meanwhile.
module nw_seq_loader #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT     = 1024,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CWIDTH-1:0]        in_char,
    output logic [LENGTH*CWIDTH-1:0] s1,
    output logic [LENGTH*CWIDTH-1:0] s2,
    output logic                     grid_reset,
    input  logic                     grid_valid,
    input  logic [SWIDTH-1:0]        grid_score,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SWIDTH-1:0]        res_score,
    output logic [CNT_WIDTH-1:0]     res_cycles,
    output logic                     res_err,
    output logic                     busy
);

    localparam int SW  = LENGTH * CWIDTH;
    localparam int CCW = $clog2(LENGTH + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CCW-1:0]       LAST_CHAR = CCW'(LENGTH - 1);
    localparam logic [HCW-1:0]       LAST_HOLD = HCW'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_SAT   = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {
        LOAD_S1,
        LOAD_S2,
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [CCW-1:0]       char_cnt;
    logic [HCW-1:0]       hold_cnt;
    logic [CNT_WIDTH-1:0] run_cnt;
    logic                 accept;

    // Combinational so the loader is ready in the first cycle after reset release.
    assign in_ready = !reset && ((state == LOAD_S1) || (state == LOAD_S2));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD_S1;
            char_cnt   <= '0;
            hold_cnt   <= '0;
            run_cnt    <= '0;
            s1         <= '0;
            s2         <= '0;
            grid_reset <= 1'b1;
            res_valid  <= 1'b0;
            res_score  <= '0;
            res_cycles <= '0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                LOAD_S1: begin
                    if (accept) begin
                        s1 <= {s1[SW-CWIDTH-1:0], in_char};
                        if (char_cnt == LAST_CHAR) begin
                            char_cnt <= '0;
                            state    <= LOAD_S2;
                        end else begin
                            char_cnt <= char_cnt + CCW'(1);
                        end
                    end
                end

                LOAD_S2: begin
                    if (accept) begin
                        s2 <= {s2[SW-CWIDTH-1:0], in_char};
                        if (char_cnt == LAST_CHAR) begin
                            char_cnt <= '0;
                            hold_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            char_cnt <= char_cnt + CCW'(1);
                        end
                    end
                end

                // Grid sees stable strings under reset for HOLD_CYCLES before release.
                HOLD: begin
                    hold_cnt <= hold_cnt + HCW'(1);
                    if (hold_cnt == LAST_HOLD) begin
                        run_cnt    <= '0;
                        grid_reset <= 1'b0;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    if (run_cnt != RUN_SAT) begin
                        run_cnt <= run_cnt + CNT_WIDTH'(1);
                    end
                    // Completion beats timeout when both land in the same cycle.
                    if (grid_valid) begin
                        res_score  <= grid_score;
                        res_cycles <= run_cnt;
                        res_err    <= 1'b0;
                        res_valid  <= 1'b1;
                        grid_reset <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else if (run_cnt == RUN_LAST) begin
                        res_score  <= '0;
                        res_cycles <= RUN_SAT;
                        res_err    <= 1'b1;
                        res_valid  <= 1'b1;
                        grid_reset <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        char_cnt  <= '0;
                        state     <= LOAD_S1;
                    end
                end

                default: begin
                    grid_reset <= 1'b1;
                    busy       <= 1'b0;
                    state      <= LOAD_S1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nw_seq_loader.sv
// Bench for nw_seq_loader: table jobs, reset corner sequences and random jobs against a job-level model.
module tb_nw_seq_loader;

    localparam int T_OUT = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_char;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic        grid_reset;
    logic        grid_valid = 1'b0;
    logic [15:0] grid_score = 16'h0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_score;
    logic [15:0] res_cycles;
    logic        res_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    int          gcnt   = 0;
    int          glat   = 1000;
    logic [15:0] gscore = 16'h0;

    nw_seq_loader #(
        .LENGTH(4), .CWIDTH(2), .SWIDTH(16), .CNT_WIDTH(16),
        .TIMEOUT(T_OUT), .HOLD_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .s1(s1), .s2(s2), .grid_reset(grid_reset),
        .grid_valid(grid_valid), .grid_score(grid_score),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_cycles(res_cycles), .res_err(res_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grid stand-in: counts cycles out of reset, completes on cycle glat; noise while held in reset.
    always @(negedge clk) begin
        if (grid_reset !== 1'b0) begin
            gcnt       = 0;
            grid_valid = 1'($urandom);
            grid_score = 16'($urandom);
        end else begin
            grid_valid = (gcnt == glat);
            grid_score = (gcnt == glat) ? gscore : 16'($urandom);
            gcnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s1"},         32'(s1),         32'h0);
        chk({tag, "_s2"},         32'(s2),         32'h0);
        chk({tag, "_grid_reset"}, 32'(grid_reset), 32'h1);
        chk({tag, "_in_ready"},   32'(in_ready),   32'h0);
        chk({tag, "_res_valid"},  32'(res_valid),  32'h0);
        chk({tag, "_res_score"},  32'(res_score),  32'h0);
        chk({tag, "_res_cycles"}, 32'(res_cycles), 32'h0);
        chk({tag, "_res_err"},    32'(res_err),    32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
    endtask

    // Assert reset mid-cycle, check values immediately, release on the next falling edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, "_ready_after"}, 32'(in_ready), 32'h1);
    endtask

    // gap: 0 = in_valid held high, 1 = toggled every other cycle, 2 = random.
    task automatic load_chars(input logic [15:0] chars, input int n, input int gap);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < n && cyc < 200) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 0);
            else               v = 1'($urandom);
            in_valid = v;
            in_char  = v ? chars[15-2*idx -: 2] : 2'($urandom);
            chk("in_ready_load", 32'(in_ready), 32'h1);
            if (v && in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (idx < n) chk("load_timeout", 32'(idx), 32'(n));
    endtask

    task automatic do_job(input logic [15:0] chars, input int gap, input int lat,
                          input logic [15:0] score, input int hold_rdy,
                          input logic [7:0] e_s1, input logic [7:0] e_s2,
                          input logic [15:0] e_score, input logic [15:0] e_cyc,
                          input logic e_err);
        int runs = 0;
        bit got  = 1'b0;
        int exp_runs;
        glat   = lat;
        gscore = score;
        load_chars(chars, 8, gap);
        chk("ready_drop",  32'(in_ready),   32'h0);
        chk("s1",          32'(s1),         32'(e_s1));
        chk("s2",          32'(s2),         32'(e_s2));
        chk("busy_hold",   32'(busy),       32'h1);
        chk("grst_hold0",  32'(grid_reset), 32'h1);
        @(negedge clk);
        chk("grst_hold1",  32'(grid_reset), 32'h1);
        @(negedge clk);
        chk("grst_run",    32'(grid_reset), 32'h0);
        for (int i = 0; i < 64; i++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            if (!grid_reset) runs++;
            @(negedge clk);
        end
        chk("res_arrive", 32'(got), 32'h1);
        exp_runs = (lat < T_OUT) ? lat + 1 : T_OUT;
        chk("run_len",     32'(runs),       32'(exp_runs));
        chk("res_score",   32'(res_score),  32'(e_score));
        chk("res_cycles",  32'(res_cycles), 32'(e_cyc));
        chk("res_err",     32'(res_err),    32'(e_err));
        chk("grst_done",   32'(grid_reset), 32'h1);
        chk("busy_done",   32'(busy),       32'h0);
        chk("ready_done",  32'(in_ready),   32'h0);
        for (int j = 0; j < hold_rdy; j++) begin
            res_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid",  32'(res_valid),  32'h1);
            chk("stall_score",  32'(res_score),  32'(e_score));
            chk("stall_cycles", 32'(res_cycles), 32'(e_cyc));
            chk("stall_err",    32'(res_err),    32'(e_err));
            chk("stall_ready",  32'(in_ready),   32'h0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_valid",  32'(res_valid), 32'h0);
        chk("hs_ready",  32'(in_ready),  32'h1);
        chk("hs_busy",   32'(busy),      32'h0);
        chk("hs_score",  32'(res_score), 32'(e_score));
        chk("hs_s1",     32'(s1),        32'(e_s1));
        chk("hs_s2",     32'(s2),        32'(e_s2));
    endtask

    typedef struct {
        logic [15:0] chars;
        int          gap;
        int          lat;
        logic [15:0] score;
        int          hold_rdy;
        logic [7:0]  e_s1;
        logic [7:0]  e_s2;
        logic [15:0] e_score;
        logic [15:0] e_cyc;
        logic        e_err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          c [8];
        logic [15:0] chars;
        logic [7:0]  m_s1;
        logic [7:0]  m_s2;
        int          lat;
        logic [15:0] score;

        tbl[0] = '{16'h1BE4, 0,   7, 16'hFFFD, 5, 8'h1B, 8'hE4, 16'hFFFD, 16'd7,  1'b0};
        tbl[1] = '{16'h1BE4, 1,   7, 16'hFFFD, 0, 8'h1B, 8'hE4, 16'hFFFD, 16'd7,  1'b0};
        tbl[2] = '{16'hFF00, 0, 100, 16'h1234, 1, 8'hFF, 8'h00, 16'h0000, 16'd16, 1'b1};
        tbl[3] = '{16'h935A, 1,  15, 16'h7FFF, 2, 8'h93, 8'h5A, 16'h7FFF, 16'd15, 1'b0};
        tbl[4] = '{16'h4001, 0,   0, 16'h8000, 0, 8'h40, 8'h01, 16'h8000, 16'd0,  1'b0};
        tbl[5] = '{16'h0000, 1,  14, 16'h0005, 3, 8'h00, 8'h00, 16'h0005, 16'd14, 1'b0};
        tbl[6] = '{16'hC3A5, 0,  16, 16'h1111, 1, 8'hC3, 8'hA5, 16'h0000, 16'd16, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 2'd0;
        res_ready = 1'b0;
        @(negedge clk);
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("por_ready_after", 32'(in_ready), 32'h1);

        for (int k = 0; k < 7; k++)
            do_job(tbl[k].chars, tbl[k].gap, tbl[k].lat, tbl[k].score, tbl[k].hold_rdy,
                   tbl[k].e_s1, tbl[k].e_s2, tbl[k].e_score, tbl[k].e_cyc, tbl[k].e_err);

        // Abort after 3 chars of s2, then a clean reload must not inherit the partial count.
        glat = 1000;
        load_chars(16'h6C93, 7, 0);
        pulse_reset("rst_s2");
        do_job(16'h2D78, 0, 3, 16'hFFFF, 0, 8'h2D, 8'h78, 16'hFFFF, 16'd3, 1'b0);

        // Abort in the middle of RUN.
        glat = 1000;
        load_chars(16'hFFFF, 8, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_run_busy", 32'(busy),       32'h1);
        chk("rst_run_grst", 32'(grid_reset), 32'h0);
        pulse_reset("rst_run");

        // Abort with a result pending.
        glat   = 2;
        gscore = 16'h0ABC;
        load_chars(16'h5A5A, 8, 0);
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        chk("rst_done_pending", 32'(res_valid), 32'h1);
        chk("rst_done_score",   32'(res_score), 32'h0ABC);
        pulse_reset("rst_done");

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 3));
            chars = 16'h0;
            m_s1  = 8'h0;
            m_s2  = 8'h0;
            for (int i = 0; i < 8; i++) chars = chars | (16'(c[i]) << (2 * (7 - i)));
            for (int i = 0; i < 4; i++) begin
                m_s1 = m_s1 + 8'(c[i]     * (1 << (2 * (3 - i))));
                m_s2 = m_s2 + 8'(c[i + 4] * (1 << (2 * (3 - i))));
            end
            lat   = int'($urandom_range(0, 20));
            score = 16'($urandom);
            if (lat < T_OUT)
                do_job(chars, 2, lat, score, int'($urandom_range(0, 3)),
                       m_s1, m_s2, score, 16'(lat), 1'b0);
            else
                do_job(chars, 2, lat, score, int'($urandom_range(0, 3)),
                       m_s1, m_s2, 16'h0, 16'(T_OUT), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
